// File: rtl/bsg_fifo_1r1w_flop_n_pkg.sv
// Shared types and helpers for the flop-based 1R1W FIFO.
// Optional occupancy output is enabled by BSG_FIFO_1R1W_FLOP_N_COUNT_EN.
package bsg_fifo_1r1w_flop_n_pkg;

  typedef enum logic [1:0] {
    e_none = 2'd0,
    e_enq  = 2'd1,
    e_deq  = 2'd2,
    e_both = 2'd3
  } fifo_op_e;

  // Pointer width for a circular index over 0..els-1; never narrower than one bit.
  function automatic int ptr_width(input int els);
    return (els > 1) ? $clog2(els) : 1;
  endfunction

endpackage

// File: rtl/bsg_fifo_1r1w_flop_n_chk.sv
// Protocol and invariant checks for bsg_fifo_1r1w_flop_n.
// Occupancy checks exist only with BSG_FIFO_1R1W_FLOP_N_COUNT_EN.
module bsg_fifo_1r1w_flop_n_chk #(
  parameter int els_p = 4
)
(
  input logic clk_i,
  input logic reset_n_i,
  input logic yumi_i,
  input logic v_o,
  input logic ready_o
`ifdef BSG_FIFO_1R1W_FLOP_N_COUNT_EN
  , input logic [$clog2(els_p+1)-1:0] count_o
`endif
);

  a_yumi_needs_valid: assert property (@(posedge clk_i) disable iff (!reset_n_i)
    yumi_i |-> v_o) else $error("yumi_i asserted while v_o=0");

  a_not_full_and_empty: assert property (@(posedge clk_i) disable iff (!reset_n_i)
    (v_o || ready_o)) else $error("fifo reports full and empty together");

`ifdef BSG_FIFO_1R1W_FLOP_N_COUNT_EN
  a_count_empty: assert property (@(posedge clk_i) disable iff (!reset_n_i)
    ((count_o == '0) == !v_o)) else $error("count_o disagrees with v_o");

  a_count_full: assert property (@(posedge clk_i) disable iff (!reset_n_i)
    ((count_o == ($clog2(els_p+1))'(els_p)) == !ready_o))
    else $error("count_o disagrees with ready_o");
`endif

endmodule

// File: rtl/bsg_fifo_circ_ptr.sv
// Circular pointer over 0..els_p-1 (non-power-of-2 depths wrap correctly).
module bsg_fifo_circ_ptr
  import bsg_fifo_1r1w_flop_n_pkg::*;
#(
  parameter int els_p = 4,
  localparam int ptr_width_lp = ptr_width(els_p)
)
(
  input  logic                    clk_i,
  input  logic                    reset_n_i,
  input  logic                    incr_i,
  output logic [ptr_width_lp-1:0] ptr_r_o,
  output logic [ptr_width_lp-1:0] ptr_n_o
);

  // Next pointer value, wrapping from the last entry back to zero.
  always_comb begin
    ptr_n_o = ptr_r_o;
    if (!incr_i) begin
      ptr_n_o = ptr_r_o;
    end else if (ptr_r_o == ptr_width_lp'(els_p - 1)) begin
      ptr_n_o = ptr_width_lp'(0);
    end else begin
      ptr_n_o = ptr_r_o + ptr_width_lp'(1);
    end
  end

  // Pointer register.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      ptr_r_o <= ptr_width_lp'(0);
    end else begin
      ptr_r_o <= ptr_n_o;
    end
  end

endmodule

// File: rtl/bsg_fifo_1r1w_flop_n.sv
// Flop-based FIFO, valid/ready in, valid->yumi out, one word/cycle for els_p >= 2.
// Define BSG_FIFO_1R1W_FLOP_N_COUNT_EN to add the registered count_o occupancy output.
module bsg_fifo_1r1w_flop_n
  import bsg_fifo_1r1w_flop_n_pkg::*;
#(
  parameter int width_p = 8,
  parameter int els_p   = 4
)
(
  input  logic               clk_i,
  input  logic               reset_n_i,
  input  logic [width_p-1:0] data_i,
  input  logic               v_i,
  output logic               ready_o,
  output logic               v_o,
  output logic [width_p-1:0] data_o,
  input  logic               yumi_i
`ifdef BSG_FIFO_1R1W_FLOP_N_COUNT_EN
  , output logic [$clog2(els_p+1)-1:0] count_o
`endif
);

  localparam int ptr_width_lp = ptr_width(els_p);

  if (els_p < 2) begin : g_bad_els
    $error("bsg_fifo_1r1w_flop_n: els_p must be >= 2");
  end
  if (width_p < 1) begin : g_bad_width
    $error("bsg_fifo_1r1w_flop_n: width_p must be >= 1");
  end

  logic                    full_r, empty_r;
  logic                    enq_s, deq_s;
  fifo_op_e                op_s;
  logic [ptr_width_lp-1:0] wr_ptr_r_s, wr_ptr_n_s, rd_ptr_r_s, rd_ptr_n_s;
  logic [width_p-1:0]      mem_r [els_p];

  // Yumi is gated with v_o so an illegal yumi cannot disturb state.
  assign enq_s = v_i & ~full_r;
  assign deq_s = yumi_i & ~empty_r;
  assign op_s  = fifo_op_e'({deq_s, enq_s});

  bsg_fifo_circ_ptr #(.els_p(els_p)) wr_ptr (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .incr_i    (enq_s),
    .ptr_r_o   (wr_ptr_r_s),
    .ptr_n_o   (wr_ptr_n_s)
  );

  bsg_fifo_circ_ptr #(.els_p(els_p)) rd_ptr (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .incr_i    (deq_s),
    .ptr_r_o   (rd_ptr_r_s),
    .ptr_n_o   (rd_ptr_n_s)
  );

  // Full/empty flags disambiguate equal pointers using the last operation.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      full_r  <= 1'b0;
      empty_r <= 1'b1;
    end else begin
      case (op_s)
        e_enq: begin
          empty_r <= 1'b0;
          full_r  <= (wr_ptr_n_s == rd_ptr_r_s);
        end
        e_deq: begin
          full_r  <= 1'b0;
          empty_r <= (rd_ptr_n_s == wr_ptr_r_s);
        end
        default: begin
          full_r  <= full_r;
          empty_r <= empty_r;
        end
      endcase
    end
  end

  // Storage: written only on enqueue; contents intentionally not reset.
  always_ff @(posedge clk_i) begin
    if (enq_s) begin
      mem_r[wr_ptr_r_s] <= data_i;
    end
  end

  assign data_o  = mem_r[rd_ptr_r_s];
  assign v_o     = ~empty_r;
  assign ready_o = ~full_r;

`ifdef BSG_FIFO_1R1W_FLOP_N_COUNT_EN
  localparam int count_width_lp = $clog2(els_p+1);
  logic [count_width_lp-1:0] count_r;

  // Occupancy counter; simultaneous enq and deq leave it unchanged.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      count_r <= count_width_lp'(0);
    end else begin
      case (op_s)
        e_enq:   count_r <= count_r + count_width_lp'(1);
        e_deq:   count_r <= count_r - count_width_lp'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  assign count_o = count_r;
`endif

  bsg_fifo_1r1w_flop_n_chk #(.els_p(els_p)) chk (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .yumi_i    (yumi_i),
    .v_o       (v_o),
    .ready_o   (ready_o)
`ifdef BSG_FIFO_1R1W_FLOP_N_COUNT_EN
    , .count_o (count_o)
`endif
  );

endmodule

// File: tb/tb_bsg_fifo_1r1w_flop_n.sv
// Scoreboard bench for bsg_fifo_1r1w_flop_n: a depth-4 and a depth-3 instance.
module tb_bsg_fifo_1r1w_flop_n;

  localparam int W = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n;
  logic [1:0]   v_s, y_s, ready_s, vo_s;
  logic [W-1:0] din [2];
  logic [W-1:0] dout [2];
`ifdef BSG_FIFO_1R1W_FLOP_N_COUNT_EN
  logic [2:0]   cnt0;
  logic [1:0]   cnt1;
`endif

  bsg_fifo_1r1w_flop_n #(.width_p(W), .els_p(4)) dut4 (
    .clk_i(clk), .reset_n_i(rst_n), .data_i(din[0]), .v_i(v_s[0]),
    .ready_o(ready_s[0]), .v_o(vo_s[0]), .data_o(dout[0]), .yumi_i(y_s[0])
`ifdef BSG_FIFO_1R1W_FLOP_N_COUNT_EN
    , .count_o(cnt0)
`endif
  );

  bsg_fifo_1r1w_flop_n #(.width_p(W), .els_p(3)) dut3 (
    .clk_i(clk), .reset_n_i(rst_n), .data_i(din[1]), .v_i(v_s[1]),
    .ready_o(ready_s[1]), .v_o(vo_s[1]), .data_o(dout[1]), .yumi_i(y_s[1])
`ifdef BSG_FIFO_1R1W_FLOP_N_COUNT_EN
    , .count_o(cnt1)
`endif
  );

  // Reference model: occupancy per FIFO plus queues of expected output words.
  int           occ [2];
  int           els [2];
  logic [W-1:0] q0 [$];
  logic [W-1:0] q1 [$];
  int           checks = 0;
  int           errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // One clock of stimulus to FIFO k; the model decides acceptance from its own occupancy.
  task automatic step(input int k, input bit v, input logic [W-1:0] d, input bit y);
    bit en, de;
    en = v && (occ[k] < els[k]);
    de = y && (occ[k] > 0);
    v_s = 2'b00;
    y_s = 2'b00;
    v_s[k] = v;
    y_s[k] = de;
    din[k] = d;
    @(posedge clk);
    #1;
    if (en) begin
      if (k == 0) q0.push_back(d);
      else        q1.push_back(d);
    end
    occ[k] = occ[k] + int'(en) - int'(de);
    v_s = 2'b00;
    y_s = 2'b00;
  endtask

  task automatic drain(input int k);
    for (int i = 0; i < 8 && occ[k] > 0; i++) step(k, 1'b0, 8'h00, 1'b1);
  endtask

  // Monitor: flag checks every cycle and pop/compare whenever a word is taken.
  always @(negedge clk) begin
    logic [W-1:0] exp_w;
    if (rst_n) begin
      for (int k = 0; k < 2; k++) begin
        chk($sformatf("v_o[%0d]", k), 32'(vo_s[k]), 32'(occ[k] > 0));
        chk($sformatf("ready_o[%0d]", k), 32'(ready_s[k]), 32'(occ[k] < els[k]));
        if (vo_s[k] && y_s[k]) begin
          if ((k == 0 && q0.size() == 0) || (k == 1 && q1.size() == 0)) begin
            checks++;
            errors++;
            $display("FAIL pop_empty[%0d] actual=%0h required=none", k, dout[k]);
          end else begin
            exp_w = (k == 0) ? q0.pop_front() : q1.pop_front();
            chk($sformatf("data_o[%0d]", k), 32'(dout[k]), 32'(exp_w));
          end
        end
      end
`ifdef BSG_FIFO_1R1W_FLOP_N_COUNT_EN
      chk("count_o[0]", 32'(cnt0), 32'(occ[0]));
      chk("count_o[1]", 32'(cnt1), 32'(occ[1]));
`endif
    end
  end

  initial begin
    els[0] = 4;
    els[1] = 3;
    occ[0] = 0;
    occ[1] = 0;
    v_s = 2'b00;
    y_s = 2'b00;
    din[0] = 8'h00;
    din[1] = 8'h00;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Partial fill, then asynchronous mid-cycle reset.
    step(0, 1'b1, 8'hA1, 1'b0);
    step(0, 1'b1, 8'hA2, 1'b0);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_v_o", 32'(vo_s[0]), 32'd0);
    chk("rst_ready_o", 32'(ready_s[0]), 32'd1);
`ifdef BSG_FIFO_1R1W_FLOP_N_COUNT_EN
    chk("rst_count_o", 32'(cnt0), 32'd0);
`endif
    occ[0] = 0;
    q0.delete();
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Fill then drain in order.
    step(0, 1'b1, 8'h11, 1'b0);
    step(0, 1'b1, 8'h22, 1'b0);
    step(0, 1'b1, 8'h33, 1'b0);
    step(0, 1'b1, 8'h44, 1'b0);
    chk("full_ready_o", 32'(ready_s[0]), 32'd0);
    drain(0);
    chk("drained_v_o", 32'(vo_s[0]), 32'd0);

    // Full-rate streaming, one word per cycle.
    for (int i = 0; i < 100; i++) step(0, 1'b1, W'(i), occ[0] > 0);
    chk("stream_occ_v_o", 32'(vo_s[0]), 32'd1);
    drain(0);

    // Full plus simultaneous yumi: 0x55 rejected, then accepted next cycle.
    step(0, 1'b1, 8'h11, 1'b0);
    step(0, 1'b1, 8'h22, 1'b0);
    step(0, 1'b1, 8'h33, 1'b0);
    step(0, 1'b1, 8'h44, 1'b0);
    step(0, 1'b1, 8'h55, 1'b1);
    chk("after_full_yumi_ready", 32'(ready_s[0]), 32'd1);
    step(0, 1'b1, 8'h55, 1'b0);
    chk("refill_ready", 32'(ready_s[0]), 32'd0);
    drain(0);

    // One entry plus enq&deq in the same cycle.
    step(0, 1'b1, 8'h66, 1'b0);
    step(0, 1'b1, 8'h77, 1'b1);
    chk("one_entry_v_o", 32'(vo_s[0]), 32'd1);
    chk("one_entry_data_o", 32'(dout[0]), 32'h77);
    drain(0);

    // Random traffic on the depth-3 instance, exercising pointer wrap.
    for (int i = 0; i < 60; i++)
      step(1, 1'($urandom_range(0, 1)), W'($urandom), 1'($urandom_range(0, 1)));
    drain(1);

    // Random traffic on the depth-4 instance.
    for (int i = 0; i < 60; i++)
      step(0, 1'($urandom_range(0, 1)), W'($urandom), 1'($urandom_range(0, 1)));
    drain(0);

    @(negedge clk);
    chk("sb_empty0", 32'(q0.size()), 32'd0);
    chk("sb_empty1", 32'(q1.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
